// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
package ifu_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned INST_W_DEF   = 32;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  // Pointer index width for a queue of the given depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch bus, decode-side and redirect signals of the prefetch unit.
interface ifu_prefetch_if
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst_data, inst_pc,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst_data, inst_pc,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a flush that overrides push/pop.
// Storage rounds DEPTH up to a power of two.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = ptr_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned SLOTS    = 1 << PW;
  localparam logic [PW:0] PTR_ZERO = {(PW+1){1'b0}};
  localparam logic [PW:0] PTR_ONE  = (PW+1)'(1'b1);

  logic [WIDTH-1:0] mem_r [SLOTS];
  logic [PW:0]      wr_ptr_r;
  logic [PW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head      = mem_r[rd_ptr_r[PW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and storage update; flush discards any same-cycle push or pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      for (int i = 0; i < SLOTS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: sequential fetch with credit-limited requests, PC-tagged
// fetch FIFO and redirect flush. Optional counters under IFU_PREFETCH_PERF_EN.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 2,
  parameter int unsigned       PC_STEP  = PC_STEP_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic          clock,
  input  logic          reset_n,
  ifu_prefetch_if.master bus,
  output logic          is_busy
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);

  localparam int unsigned    CW       = $clog2(MAX_OUT + 1);
  localparam int unsigned    FPW      = ptr_w(DEPTH);
  localparam int unsigned    QPW      = ptr_w(MAX_OUT);
  localparam int unsigned    EW       = ADDR_W + INST_W;
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  ifu_state_e        state_r, state_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_s;
  logic [CW-1:0]     outstanding_r, outstanding_s;
  logic [CW-1:0]     drop_cnt_r, drop_cnt_s;
  logic              issue_en_r;

  logic              req_valid_s, accept_s, resp_ok_s, flush_s;
  logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [FPW:0]      fifo_count_s;
  logic [EW-1:0]     fifo_head_s;
  logic              q_push_s, q_pop_s, q_full_s, q_empty_s;
  logic [QPW:0]      q_count_s;
  logic [ADDR_W-1:0] q_head_s;

  // A response with nothing in flight is a bus error; it must not underflow the counters.
  assign resp_ok_s = bus.resp_valid && (outstanding_r != CNT_ZERO);

  ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fetch_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush_s),
    .push      (fifo_push_s),
    .push_data ({q_head_s, bus.resp_data}),
    .pop       (fifo_pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  ifu_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_pc_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush_s),
    .push      (q_push_s),
    .push_data (fetch_pc_r),
    .pop       (q_pop_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s),
    .head      (q_head_s)
  );

  // Next-state, credit and queue-control logic; redirect overrides all other events.
  always_comb begin
    state_s       = state_r;
    fetch_pc_s    = fetch_pc_r;
    outstanding_s = outstanding_r;
    drop_cnt_s    = drop_cnt_r;
    flush_s       = 1'b0;
    fifo_push_s   = 1'b0;
    fifo_pop_s    = 1'b0;
    q_push_s      = 1'b0;
    q_pop_s       = 1'b0;

    // The credit sum keeps a FIFO slot reserved for every in-flight request.
    req_valid_s = issue_en_r && (state_r == RUN) && !bus.redirect_valid &&
                  (32'(outstanding_r) < MAX_OUT) && (32'(q_count_s) < MAX_OUT) &&
                  ((32'(outstanding_r) + 32'(fifo_count_s)) < DEPTH);
    accept_s    = req_valid_s && bus.req_ready;

    if (bus.redirect_valid) begin
      flush_s       = 1'b1;
      fetch_pc_s    = bus.redirect_pc;
      outstanding_s = outstanding_r - CW'(resp_ok_s);
      drop_cnt_s    = outstanding_r - CW'(resp_ok_s);
      if (outstanding_r - CW'(resp_ok_s) != CNT_ZERO) begin
        state_s = DRAIN;
      end else begin
        state_s = RUN;
      end
    end else begin
      if (accept_s) begin
        fetch_pc_s = fetch_pc_r + ADDR_W'(PC_STEP);
        q_push_s   = !q_full_s;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
      fifo_pop_s    = bus.inst_ready && !fifo_empty_s;
      outstanding_s = outstanding_r + CW'(accept_s) - CW'(resp_ok_s);
      case (state_r)
        RUN: begin
          if (resp_ok_s) begin
            fifo_push_s = !fifo_full_s;
            q_pop_s     = !q_empty_s;
          end else begin
            fifo_push_s = 1'b0;
          end
        end
        DRAIN: begin
          if (resp_ok_s && (drop_cnt_r != CNT_ZERO)) begin
            drop_cnt_s = drop_cnt_r - CW'(1'b1);
          end else begin
            drop_cnt_s = drop_cnt_r;
          end
          if (drop_cnt_s == CNT_ZERO) begin
            state_s = RUN;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // State and counter registers; issue_en_r holds off requests while reset is applied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= RUN;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
      issue_en_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      outstanding_r <= outstanding_s;
      drop_cnt_r    <= drop_cnt_s;
      issue_en_r    <= 1'b1;
    end
  end

  assign bus.req_valid  = req_valid_s;
  assign bus.req_addr   = fetch_pc_r;
  assign bus.inst_valid = !fifo_empty_s;
  assign bus.inst_pc    = fifo_head_s[EW-1:INST_W];
  assign bus.inst_data  = fifo_head_s[INST_W-1:0];
  assign is_busy        = (outstanding_r != CNT_ZERO) || (drop_cnt_r != CNT_ZERO) || !fifo_empty_s;

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Pop and starvation counters; a pop cancelled by a redirect is not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      if (fifo_pop_s && !bus.redirect_valid) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (bus.inst_ready && fifo_empty_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a bus model tags requests with a redirect epoch
// so stale responses are excluded from the expected instruction stream.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } bus_req_t;

  logic clock;
  logic reset_n;
  logic is_busy;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  ifu_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  ifu_prefetch dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master),
    .is_busy (is_busy)
`ifdef IFU_PREFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bus_req_t     bus_q [$];
  fetch_entry_t exp_q [$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_acc   = 0;
  int          n_pop   = 0;
  int          epoch   = 0;
  logic        req_ready_d, inst_ready_d, resp_en, rd_req;
  logic [31:0] rd_pc, exp_addr, last_pop_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, observe #1 later, update the model for the coming edge.
  task automatic step();
    bus_req_t     r;
    fetch_entry_t e;
    logic         have;
    @(negedge clock);
    cyc++;
    bus.req_ready      = req_ready_d;
    bus.inst_ready     = inst_ready_d;
    bus.redirect_valid = rd_req;
    bus.redirect_pc    = rd_pc;
    have   = 1'b0;
    r.addr = 32'd0; r.epoch = 0; r.due = 0;
    if (resp_en && bus_q.size() != 0 && bus_q[0].due <= cyc) begin
      r = bus_q.pop_front();
      have = 1'b1;
      bus.resp_valid = 1'b1;
      bus.resp_data  = inst_of(r.addr);
    end else begin
      bus.resp_valid = 1'b0;
      bus.resp_data  = 32'd0;
    end
    #1;
    if (rd_req) check_eq("redirect_withdraws_req", 32'(bus.req_valid), 32'd0);
    if (bus.req_valid && bus.req_ready) begin
      check_eq("req_addr", bus.req_addr, exp_addr);
      bus_q.push_back('{addr: bus.req_addr, epoch: epoch, due: cyc + 1});
      exp_addr += 32'd4;
      n_acc++;
    end
    if (bus.inst_valid && bus.inst_ready && !rd_req) begin
      check_eq("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("inst_pc", bus.inst_pc, e.pc);
        check_eq("inst_data", bus.inst_data, e.inst);
      end
      last_pop_pc = bus.inst_pc;
      n_pop++;
    end
    if (have && r.epoch == epoch && !rd_req) exp_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
    if (rd_req) begin
      exp_q.delete();
      epoch++;
      exp_addr = rd_pc;
      rd_req   = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req_ready_d = 1'b0; inst_ready_d = 1'b0; resp_en = 1'b0; rd_req = 1'b0; rd_pc = 32'd0;
    bus.req_ready = 1'b0; bus.inst_ready = 1'b0; bus.resp_valid = 1'b0;
    bus.resp_data = 32'd0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    bus_q.delete();
    exp_q.delete();
    epoch++;
    exp_addr = 32'h8000_0000;
    #1;
    check_eq("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("rst_is_busy", 32'(is_busy), 32'd0);
`ifdef IFU_PREFETCH_PERF_EN
    check_eq("rst_perf_fetched", perf_fetched, 32'd0);
    check_eq("rst_perf_stall", perf_stall, 32'd0);
`endif
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset_n = 1'b0;
    last_pop_pc = 32'd0;

    // Streaming: one instruction per cycle at steady state.
    do_reset();
    req_ready_d = 1'b1; inst_ready_d = 1'b1; resp_en = 1'b1;
    repeat (4) step();
    base = n_pop;
    repeat (10) step();
    check_eq("t1_throughput", 32'(n_pop - base), 32'd10);

    // Decode stalled: credits stop at DEPTH requests.
    do_reset();
    req_ready_d = 1'b1; resp_en = 1'b1; inst_ready_d = 1'b0;
    base = n_acc;
    repeat (12) step();
    check_eq("t2_accepted", 32'(n_acc - base), 32'd4);
    check_eq("t2_req_valid_low", 32'(bus.req_valid), 32'd0);
    check_eq("t2_fifo_full_valid", 32'(bus.inst_valid), 32'd1);
    check_eq("t2_busy", 32'(is_busy), 32'd1);
    req_ready_d = 1'b0; inst_ready_d = 1'b1;
    base = n_pop;
    repeat (5) step();
    check_eq("t2_pops", 32'(n_pop - base), 32'd4);
    check_eq("t2_last_pc", last_pop_pc, 32'h8000_000C);
    check_eq("t2_empty", 32'(bus.inst_valid), 32'd0);

    // Bus backpressure: request held stable.
    do_reset();
    req_ready_d = 1'b0; inst_ready_d = 1'b1; resp_en = 1'b1;
    base = n_acc;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_req_valid", 32'(bus.req_valid), 32'd1);
      check_eq("t3_req_addr", bus.req_addr, 32'h8000_0000);
    end
    check_eq("t3_no_accept", 32'(n_acc - base), 32'd0);
    req_ready_d = 1'b1;
    step();
    check_eq("t3_accept_once", 32'(n_acc - base), 32'd1);

    // Redirect with two in flight: both responses dropped, fetch resumes at 0x100.
    do_reset();
    req_ready_d = 1'b1; resp_en = 1'b0; inst_ready_d = 1'b1;
    base = n_acc;
    for (int g = 0; g < 10 && (n_acc - base) < 2; g++) step();
    check_eq("t4_two_out", 32'(n_acc - base), 32'd2);
    step();
    check_eq("t4_credit_block", 32'(bus.req_valid), 32'd0);
    rd_req = 1'b1; rd_pc = 32'h0000_0100;
    step();
    resp_en = 1'b1;
    step();
    check_eq("t4_drain_a", 32'(bus.req_valid), 32'd0);
    check_eq("t4_drain_busy", 32'(is_busy), 32'd1);
    step();
    check_eq("t4_drain_b", 32'(bus.req_valid), 32'd0);
    step();
    check_eq("t4_resume_valid", 32'(bus.req_valid), 32'd1);
    check_eq("t4_resume_addr", bus.req_addr, 32'h0000_0100);
    base = n_pop;
    for (int g = 0; g < 10 && n_pop == base; g++) step();
    check_eq("t4_first_pop_seen", 32'(n_pop != base), 32'd1);
    check_eq("t4_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect coinciding with the last response and a pop.
    do_reset();
    req_ready_d = 1'b1; resp_en = 1'b1; inst_ready_d = 1'b0;
    base = n_acc;
    for (int g = 0; g < 10 && (n_acc - base) < 2; g++) step();
    req_ready_d = 1'b0; resp_en = 1'b0;
    step();
    check_eq("t5_fifo_one", 32'(bus.inst_valid), 32'd1);
    rd_req = 1'b1; rd_pc = 32'h0000_0200; resp_en = 1'b1; inst_ready_d = 1'b1; req_ready_d = 1'b1;
    step();
    step();
    check_eq("t5_req_valid", 32'(bus.req_valid), 32'd1);
    check_eq("t5_req_addr", bus.req_addr, 32'h0000_0200);
    check_eq("t5_fifo_empty", 32'(bus.inst_valid), 32'd0);
    check_eq("t5_not_busy", 32'(is_busy), 32'd0);

`ifdef IFU_PREFETCH_PERF_EN
    // Three pops followed by two starved cycles.
    do_reset();
    req_ready_d = 1'b1; resp_en = 1'b1; inst_ready_d = 1'b0;
    base = n_acc;
    for (int g = 0; g < 10 && (n_acc - base) < 3; g++) step();
    req_ready_d = 1'b0;
    repeat (3) step();
    inst_ready_d = 1'b1;
    repeat (5) step();
    inst_ready_d = 1'b0;
    step();
    check_eq("t6_perf_fetched", perf_fetched, 32'd3);
    check_eq("t6_perf_stall", perf_stall, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
